timer_arbiter: RTL and testbench

TIMER_ARBITER -- requirements
Module: timer_arbiter

---
 rtl/timer_arbiter.sv | 134 +++++++++++++
 tb/tb_timer_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_arbiter.sv
// Two-requester interval timer: edge-detected requests queue one deep, round-robin grant, then a DUR_x-cycle run.
// Grant 2 edges after a request edge, END_x pulse 1 cycle after edge grant+DUR_x; no backpressure, excess edges dropped.
module timer_arbiter #(
    parameter int CNT_W = 26,
    parameter int DUR_1 = 25000000,
    parameter int DUR_2 = 50000000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START_1,
    input  logic       START_2,
    input  logic       ABORT,
    output logic       END_1,
    output logic       END_2,
    output logic       BUSY,
    output logic [1:0] OWNER
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LOAD_1 = CNT_W'(DUR_1 - 1);
    localparam logic [CNT_W-1:0] LOAD_2 = CNT_W'(DUR_2 - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_start_1_q;
    logic             r_start_2_q;
    logic             r_pend_1;
    logic             r_pend_2;
    logic             r_last_2;
    logic             r_end_1;
    logic             r_end_2;
    logic             r_busy;
    logic [1:0]       r_owner;

    logic w_det_1;
    logic w_det_2;
    logic w_grant_1;
    logic w_grant_2;

    assign w_det_1 = START_1 & ~r_start_1_q;
    assign w_det_2 = START_2 & ~r_start_2_q;

    // r_last_2 set means requester 2 was served last, so requester 1 wins a tie
    assign w_grant_1 = (r_state == S_IDLE) & r_pend_1 & (~r_pend_2 | r_last_2);
    assign w_grant_2 = (r_state == S_IDLE) & r_pend_2 & (~r_pend_1 | ~r_last_2);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_start_1_q <= 1'b0;
            r_start_2_q <= 1'b0;
            r_pend_1    <= 1'b0;
            r_pend_2    <= 1'b0;
            r_last_2    <= 1'b1;
            r_end_1     <= 1'b0;
            r_end_2     <= 1'b0;
            r_busy      <= 1'b0;
            r_owner     <= 2'b00;
        end else begin
            r_start_1_q <= START_1;
            r_start_2_q <= START_2;
            r_end_1     <= 1'b0;
            r_end_2     <= 1'b0;
            if (ABORT) begin
                r_state  <= S_IDLE;
                r_cnt    <= '0;
                r_pend_1 <= 1'b0;
                r_pend_2 <= 1'b0;
                r_busy   <= 1'b0;
                r_owner  <= 2'b00;
            end else begin
                // Grants only ever consume a flag that was already set, so set and clear never collide
                if (w_det_1 && !r_pend_1) begin
                    r_pend_1 <= 1'b1;
                end else if (w_grant_1) begin
                    r_pend_1 <= 1'b0;
                end
                if (w_det_2 && !r_pend_2) begin
                    r_pend_2 <= 1'b1;
                end else if (w_grant_2) begin
                    r_pend_2 <= 1'b0;
                end

                case (r_state)
                    S_IDLE: begin
                        if (w_grant_1) begin
                            r_state <= S_RUN;
                            r_cnt   <= LOAD_1;
                            r_owner <= 2'b01;
                            r_busy  <= 1'b1;
                        end else if (w_grant_2) begin
                            r_state <= S_RUN;
                            r_cnt   <= LOAD_2;
                            r_owner <= 2'b10;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (r_cnt == '0) begin
                            r_state <= S_DONE;
                            r_end_1 <= r_owner[0];
                            r_end_2 <= r_owner[1];
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                    S_DONE: begin
                        r_state  <= S_IDLE;
                        r_owner  <= 2'b00;
                        r_busy   <= 1'b0;
                        r_last_2 <= r_owner[1];
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_owner <= 2'b00;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign END_1 = r_end_1;
    assign END_2 = r_end_2;
    assign BUSY  = r_busy;
    assign OWNER = r_owner;

endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter with DUR_1=4, DUR_2=6: time-based reference model checked every cycle plus directed literal checks.
module tb_timer_arbiter;

    localparam int D1 = 4;
    localparam int D2 = 6;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       START_1 = 1'b0;
    logic       START_2 = 1'b0;
    logic       ABORT = 1'b0;
    logic       END_1;
    logic       END_2;
    logic       BUSY;
    logic [1:0] OWNER;

    int total = 0;
    int bad = 0;
    int e = 0;
    bit chk_en = 0;
    int ep1 = 0;
    int ep2 = 0;

    timer_arbiter #(.CNT_W(4), .DUR_1(D1), .DUR_2(D2)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START_1(START_1),
        .START_2(START_2),
        .ABORT  (ABORT),
        .END_1  (END_1),
        .END_2  (END_2),
        .BUSY   (BUSY),
        .OWNER  (OWNER)
    );

    always #5 CLK = ~CLK;

    task automatic cmp(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: a grant at edge g owns the timer until edge g+DUR+1, END at edge g+DUR.
    int m_n = 0;
    int m_g = 0;
    int m_owner = 0;
    int m_last = 2;
    bit m_p1 = 0, m_p2 = 0, m_prev1 = 0, m_prev2 = 0;

    function automatic int dur_of(input int who);
        return (who == 1) ? D1 : D2;
    endfunction

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            m_n = 0; m_g = 0; m_owner = 0; m_last = 2;
            m_p1 = 0; m_p2 = 0; m_prev1 = 0; m_prev2 = 0;
        end else begin
            bit d1, d2, o1, o2;
            m_n++;
            d1 = START_1 && !m_prev1;
            d2 = START_2 && !m_prev2;
            m_prev1 = START_1;
            m_prev2 = START_2;
            o1 = m_p1;
            o2 = m_p2;
            if (ABORT) begin
                m_owner = 0; m_p1 = 0; m_p2 = 0;
            end else begin
                if (m_owner == 0) begin
                    if (o1 && (!o2 || m_last == 2)) begin
                        m_owner = 1; m_g = m_n; m_p1 = 0;
                    end else if (o2) begin
                        m_owner = 2; m_g = m_n; m_p2 = 0;
                    end
                end else if (m_n == m_g + dur_of(m_owner) + 1) begin
                    m_last = m_owner;
                    m_owner = 0;
                end
                if (d1 && !o1) m_p1 = 1;
                if (d2 && !o2) m_p2 = 1;
            end
        end
    end

    bit prev_e1 = 0, prev_e2 = 0;
    always @(negedge CLK) begin
        if (chk_en) begin
            int x1, x2;
            x1 = (m_owner == 1 && m_n == m_g + D1) ? 1 : 0;
            x2 = (m_owner == 2 && m_n == m_g + D2) ? 1 : 0;
            cmp("model_owner", OWNER, m_owner);
            cmp("model_busy", BUSY, (m_owner != 0) ? 1 : 0);
            cmp("model_end1", END_1, x1);
            cmp("model_end2", END_2, x2);
            if (END_1 || END_2) begin
                cmp("end_exclusive", END_1 & END_2, 0);
                cmp("end1_width", END_1 & prev_e1, 0);
                cmp("end2_width", END_2 & prev_e2, 0);
            end
            if (END_1 && !prev_e1) ep1++;
            if (END_2 && !prev_e2) ep2++;
        end
        prev_e1 = END_1;
        prev_e2 = END_2;
    end

    task automatic go(input int k);
        while (e < k) begin
            @(posedge CLK);
            #1;
            e++;
        end
    endtask

    task automatic start_scn();
        @(posedge CLK);
        #1;
        e = 0;
    endtask

    initial begin
        int s1, s2;
        repeat (3) @(posedge CLK);
        #1;
        cmp("reset_owner", OWNER, 0);
        cmp("reset_busy", BUSY, 0);
        cmp("reset_ends", {END_1, END_2}, 0);
        RESET = 1'b1;
        chk_en = 1;

        // Tie after reset: 1, then 2, then a fresh tie goes to 1 again
        start_scn();
        START_1 = 1; START_2 = 1;
        go(2);  cmp("tie_first_owner", OWNER, 1);
        START_1 = 0; START_2 = 0;
        go(6);  cmp("tie_end1", END_1, 1);
        go(8);  cmp("tie_second_owner", OWNER, 2);
        go(13); cmp("tie_end2_early", END_2, 0);
        go(14); cmp("tie_end2", END_2, 1);
        go(15); START_1 = 1; START_2 = 1;
        go(17); cmp("tie_again_owner", OWNER, 1);
        START_1 = 0; START_2 = 0;
        go(23); cmp("tie_again_then2", OWNER, 2);
        go(31); cmp("tie_drained", OWNER, 0);

        // Single request timing
        start_scn();
        START_1 = 1;
        go(1);  cmp("single_owner_e1", OWNER, 0);
        go(2);  cmp("single_owner_e2", OWNER, 1);
        START_1 = 0;
        go(5);  cmp("single_end_e5", END_1, 0);
        go(6);  cmp("single_end_e6", END_1, 1);
        cmp("single_busy_e6", BUSY, 1);
        go(7);  cmp("single_end_e7", END_1, 0);
        cmp("single_busy_e7", BUSY, 0);

        // Queue depth one: two toggles during the run yield one extra interval
        start_scn();
        s1 = ep1;
        START_1 = 1;
        go(1); START_1 = 0;
        go(3); START_1 = 1;
        go(4); START_1 = 0;
        go(5); START_1 = 1;
        go(6); START_1 = 0;
        go(12); cmp("queue_second_end", END_1, 1);
        go(20); cmp("queue_end1_count", ep1 - s1, 2);
        cmp("queue_idle", OWNER, 0);
        s1 = ep1;
        START_1 = 1;
        go(40); START_1 = 0;
        go(45); cmp("held_end1_count", ep1 - s1, 1);

        // Abort while 1 runs and 2 is pending
        start_scn();
        s1 = ep1; s2 = ep2;
        START_1 = 1;
        go(1); START_1 = 0;
        go(3); START_2 = 1;
        go(4); START_2 = 0; ABORT = 1;
        go(5); ABORT = 0;
        cmp("abort_owner", OWNER, 0);
        cmp("abort_busy", BUSY, 0);
        go(20);
        cmp("abort_no_end1", ep1 - s1, 0);
        cmp("abort_no_end2", ep2 - s2, 0);
        cmp("abort_stays_idle", OWNER, 0);

        // Asynchronous reset mid-run, then requester 2 times normally
        start_scn();
        s1 = ep1; s2 = ep2;
        START_1 = 1;
        go(1); START_1 = 0;
        go(4); cmp("rst_pre_owner", OWNER, 1);
        RESET = 0;
        #1;
        cmp("rst_async_owner", OWNER, 0);
        cmp("rst_async_busy", BUSY, 0);
        go(5); RESET = 1;
        go(6); START_2 = 1;
        go(8); cmp("rst_owner2", OWNER, 2);
        START_2 = 0;
        go(13); cmp("rst_end2_e13", END_2, 0);
        go(14); cmp("rst_end2_e14", END_2, 1);
        go(16); cmp("rst_no_end1", ep1 - s1, 0);
        cmp("rst_one_end2", ep2 - s2, 1);

        // START already high across reset release counts on the first edge
        start_scn();
        RESET = 0;
        START_1 = 1;
        go(1); RESET = 1;
        e = 0;
        go(1); cmp("rel_owner_e1", OWNER, 0);
        go(2); cmp("rel_owner_e2", OWNER, 1);
        go(6); cmp("rel_end1", END_1, 1);
        go(12); START_1 = 0;
        cmp("rel_single", OWNER, 0);
        go(14);

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
